// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and buffer entry type for the instruction fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of fetch entries with flush; push when full and pop when empty are ignored
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [CW-1:0] count
);
    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic push_ok, pop_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        pop_ok = pop && (count_q != '0);
        push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);
        mem_d = mem_q;
        if (push_ok) mem_d[wr_q] = din;
        wr_d = flush ? '0 : push_ok ? nxt(wr_q) : wr_q;
        rd_d = flush ? '0 : pop_ok ? nxt(rd_q) : rd_q;
        count_d = flush ? '0 : count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end

    assign dout = mem_q[rd_q];
    assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing credit-limited fetches into a decode buffer; FETCH_BYPASS_EN forwards into an empty buffer
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int BUF_DEPTH = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instruction,
    output logic [XLEN-1:0] out_pc
);
    localparam int BW = $clog2(BUF_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0] disc_q, disc_d, outstanding;
    logic [BW-1:0] buf_count;
    fetch_entry_t buf_head, pcq_head, resp_entry;
    logic req_fire, resp_keep, bypass, buf_push, buf_pop;
    logic unused_bits;

    fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_pcq (
        .clk(clk), .rst(rst), .push(req_fire), .pop(imem_resp_valid), .flush(1'b0),
        .din('{instruction: '0, pc: pc_q}), .dout(pcq_head), .count(outstanding)
    );

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk(clk), .rst(rst), .push(buf_push), .pop(buf_pop), .flush(redirect_valid),
        .din(resp_entry), .dout(buf_head), .count(buf_count)
    );

    // Each accepted request reserves a buffer slot, so a response can always be pushed
    assign imem_req_valid = !rst && !redirect_valid
        && (32'(outstanding) + 32'(buf_count) < 32'(BUF_DEPTH))
        && (32'(outstanding) < 32'(MAX_OUTSTANDING));
    assign imem_req_addr = pc_q;
    assign unused_bits = ^{pcq_head.instruction, redirect_pc[1:0]};

    always_comb begin
        req_fire = imem_req_valid && imem_req_ready;
        resp_keep = imem_resp_valid && (disc_q == '0) && !redirect_valid;
`ifdef FETCH_BYPASS_EN
        bypass = resp_keep && (buf_count == '0);
`else
        bypass = 1'b0;
`endif
        resp_entry = '{instruction: imem_resp_data, pc: pcq_head.pc};
        out_valid = bypass || (buf_count != '0);
        {out_instruction, out_pc} = bypass ? resp_entry : buf_head;
        buf_pop = (buf_count != '0) && out_ready;
        buf_push = resp_keep && !(bypass && out_ready);
        pc_d = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : req_fire ? pc_q + XLEN'(INSTR_BYTES) : pc_q;
        disc_d = redirect_valid ? outstanding - OW'(imem_resp_valid)
               : (imem_resp_valid && (disc_q != '0)) ? disc_q - OW'(1) : disc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
            disc_q <= '0;
        end else begin
            pc_q <= pc_d;
            disc_q <= disc_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a request/response reference model
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam int BUF_DEPTH = 2;
    localparam int MAX_OUT = 2;
    localparam logic [31:0] RST_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_LAT = 1;
`else
    localparam int FIRST_LAT = 2;
`endif

    logic clk = 1'b0, rst = 1'b0;
    logic imem_req_valid, imem_req_ready = 1'b0, imem_resp_valid = 1'b0;
    logic redirect_valid = 1'b0, out_valid, out_ready = 1'b0;
    logic [31:0] imem_req_addr, imem_resp_data = '0, redirect_pc = '0, out_instruction, out_pc;

    fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(BUF_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
    req_t mem_q[$];
    fetch_entry_t exp_q[$];
    int checks = 0, errors = 0, cyc = 0, epoch = 0, last_due = 0;
    int rdy_pct = 100, ordy_pct = 100, lat_min = 1, lat_max = 1, redir_mode = 0, redir_pct = 0;
    int accepts = 0, outs = 0, first_acc = -1, first_out = -1, redir_cyc = -10, redir_fired = 0;
    int n_before, avail, lat;
    logic [31:0] redir_target = '0, exp_pc = RST_PC, first_after = '0;
    logic exp_rv;
    bit started = 0, got_after = 0;
    req_t r;
    fetch_entry_t e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ NOP;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Driver: memory responder, decode readiness and redirect stimulus, all changed at negedge
    initial forever begin
        @(negedge clk);
        imem_req_ready = $urandom_range(99) < rdy_pct;
        out_ready = $urandom_range(99) < ordy_pct;
        imem_resp_valid = (mem_q.size() > 0) ? (mem_q[0].due <= cyc) : 1'b0;
        imem_resp_data = imem_resp_valid ? mem_word(mem_q[0].addr) : $urandom;
        redirect_valid = 1'b0;
        if (redir_mode == 1) redirect_valid = (mem_q.size() == 2);
        if (redir_mode == 2) redirect_valid = imem_resp_valid && (exp_q.size() > 0) && out_ready;
        if (redir_mode == 3) redirect_valid = $urandom_range(99) < redir_pct;
        if (redirect_valid) begin
            redirect_pc = (redir_mode == 3)
                ? ((($urandom_range(3) == 0) ? 32'hFFFF_FF00 : 32'h0) | ($urandom & 32'hFFF)) : redir_target;
            if (redir_mode != 3) redir_mode = 0;
            redir_fired++;
        end
    end

    // Monitor: tracks issued requests, builds expected outputs from responses, checks decode handshakes
    initial forever begin
        @(negedge clk);
        #1;
        if (started && !rst) begin
            exp_rv = !redirect_valid && (mem_q.size() + exp_q.size() < BUF_DEPTH) && (mem_q.size() < MAX_OUT);
            chk("req_valid_credit", 32'(imem_req_valid), 32'(exp_rv));
            n_before = exp_q.size();
            if (imem_resp_valid) begin
                r = mem_q.pop_front();
                if (r.epoch == epoch && !redirect_valid)
                    exp_q.push_back('{instruction: mem_word(r.addr), pc: r.addr});
            end
            if (out_valid && out_ready) begin
                outs++;
                if (first_out < 0) first_out = cyc;
`ifdef FETCH_BYPASS_EN
                avail = exp_q.size();
`else
                avail = n_before;
`endif
                if (avail == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got out_pc %h, expected no output", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instruction", out_instruction, e.instruction);
                end
                if (!got_after) begin
                    got_after = 1;
                    first_after = out_pc;
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                epoch++;
                exp_pc = {redirect_pc[31:2], 2'b00};
                redir_cyc = cyc;
                got_after = 0;
            end else if (cyc == redir_cyc + 1) begin
                chk("flush_out_valid", 32'(out_valid), 32'd0);
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_pc);
                if (first_acc < 0) first_acc = cyc;
                lat = int'($urandom_range(lat_max, lat_min));
                last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                mem_q.push_back('{addr: imem_req_addr, due: last_due, epoch: epoch});
                exp_pc += 32'd4;
                accepts++;
            end
        end
        cyc++;
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        imem_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        redir_mode = 0;
        mem_q.delete();
        exp_q.delete();
        exp_pc = RST_PC;
        last_due = 0;
        accepts = 0;
        outs = 0;
        first_acc = -1;
        first_out = -1;
        got_after = 0;
        redir_cyc = -10;
        started = 1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instruction", out_instruction, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        rdy_pct = 0;
        ordy_pct = 100;
        redir_mode = 0;
        while ((mem_q.size() != 0 || exp_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (mem_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d in flight and %0d buffered, expected 0 and 0", name, mem_q.size(), exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1 chk({name, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rdy_pct = 100; ordy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (12) @(posedge clk);
        chk("first_out_latency", 32'(first_out - first_acc), 32'(FIRST_LAT));
        chk("seq_progress", 32'(outs >= 3), 32'd1);

        rdy_pct = 100; ordy_pct = 0;
        do_reset();
        repeat (10) @(posedge clk);
        chk("stall_accepts", 32'(accepts), 32'(BUF_DEPTH));
        #1;
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        ordy_pct = 100;
        repeat (10) @(posedge clk);
        chk("stall_resume", 32'(accepts > BUF_DEPTH && outs >= BUF_DEPTH), 32'd1);

        lat_min = 3; lat_max = 3;
        do_reset();
        redir_target = 32'h100;
        redir_fired = 0;
        redir_mode = 1;
        repeat (20) @(posedge clk);
        redir_mode = 0;
        chk("redir_c_fired", 32'(redir_fired), 32'd1);
        chk("redir_c_got_out", 32'(got_after), 32'd1);
        chk("redir_c_first_pc", first_after, 32'h100);
        drain("redir_c");

        lat_min = 1; lat_max = 1; rdy_pct = 100; ordy_pct = 50;
        do_reset();
        redir_target = 32'h203;
        redir_fired = 0;
        redir_mode = 2;
        repeat (60) @(posedge clk);
        chk("redir_d_fired", 32'(redir_fired), 32'd1);
        drain("redir_d");
        chk("redir_d_first_pc", first_after, 32'h200);

        rdy_pct = 50; ordy_pct = 60; lat_min = 1; lat_max = 3; redir_pct = 2;
        do_reset();
        redir_mode = 3;
        repeat (1000) @(posedge clk);
        drain("random");
        chk("random_progress", 32'(outs > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
